// File: rtl/clean_stream_pkg.sv
// Shared types, width helpers and default parameters for the clean stream baselines.
package clean_stream_pkg;

    localparam int unsigned DefDataWidth     = 8;
    localparam int unsigned DefDepth         = 4;
    localparam int unsigned DefCntWidth      = 16;
    localparam logic [7:0]  DefDataIncrement = 8'd2;
    localparam logic [15:0] DefThreshold     = 16'd255;

    typedef enum logic [1:0] {
        StEmpty,
        StPartial,
        StFull
    } fifo_state_e;

    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/clean_fifo_mem.sv
// Depth x Width register array with one synchronous write port and one async read port.
module clean_fifo_mem #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [Width-1:0]         rdata_o
);

    // Storage is intentionally not reset; valid tracking lives in the owner.
    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/clean3_stream_fifo.sv
// Trojan-free valid/ready stream FIFO with an observability-only transfer counter
// and sticky threshold flag.
module clean3_stream_fifo
    import clean_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH                = DefDataWidth,
    parameter int unsigned DEPTH                     = DefDepth,
    parameter int unsigned CNT_WIDTH                 = DefCntWidth,
    parameter logic [7:0]  DATA_INCREMENT            = DefDataIncrement,
    parameter logic [15:0] TRIGGER_COUNTER_THRESHOLD = DefThreshold
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic [CNT_WIDTH-1:0]          xfer_count,
    output logic                          thr_hit
);

    localparam int unsigned LW = level_w(DEPTH);
    localparam int unsigned PW = ptr_w(DEPTH);
    localparam logic [LW-1:0]        LvlFull = LW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] Thr     = CNT_WIDTH'(TRIGGER_COUNTER_THRESHOLD);

    // DATA_INCREMENT exists only for family parameter compatibility.
    if (DATA_INCREMENT != 8'd0) begin : g_incr_compat
    end

    logic [LW-1:0]        level_q, level_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] xfer_q, xfer_d;
    logic                 thr_q, thr_d;
    logic                 in_ready_q, in_ready_d;
    logic                 push, pop;
    logic [DATA_WIDTH-1:0] rdata;
    fifo_state_e          state;

    clean_fifo_mem #(
        .Width (DATA_WIDTH),
        .Depth (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    always_comb begin
        state = StPartial;
        if (level_q == '0) begin
            state = StEmpty;
        end else if (level_q == LvlFull) begin
            state = StFull;
        end
    end

    assign out_valid = (state != StEmpty);
    assign in_ready  = in_ready_q;
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        level_d    = level_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        xfer_d     = xfer_q;
        thr_d      = thr_q | (xfer_q == Thr);
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            xfer_d   = xfer_q + CNT_WIDTH'(1);
        end
        // Registered ready: never a combinational path from out_ready.
        in_ready_d = (level_d != LvlFull);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            xfer_q     <= '0;
            thr_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            xfer_q     <= xfer_d;
            thr_q      <= thr_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out_data   = out_valid ? rdata : '0;
    assign level      = level_q;
    assign xfer_count = xfer_q;
    assign thr_hit    = thr_q;

endmodule

// File: tb/tb_clean3_stream_fifo.sv
// Directed self-checking bench for clean3_stream_fifo; a second instance with a
// 4-bit counter shares all inputs to exercise counter wrap.
module tb_clean3_stream_fifo;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;

    logic        in_ready, out_valid, thr_hit;
    logic [7:0]  out_data;
    logic [2:0]  level;
    logic [15:0] xfer_count;

    logic        in_ready1, out_valid1, thr_hit1;
    logic [7:0]  out_data1;
    logic [2:0]  level1;
    logic [3:0]  xfer_count1;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_xfer;
    logic        exp_thr, exp_thr1;
    logic [3:0]  exp_xfer1;
    logic [7:0]  q[$];
    logic [7:0]  exp_word;
    int          pushed;

    clean3_stream_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .xfer_count (xfer_count),
        .thr_hit    (thr_hit)
    );

    clean3_stream_fifo #(
        .CNT_WIDTH (4)
    ) dut_w4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready1),
        .in_data    (in_data),
        .out_valid  (out_valid1),
        .out_ready  (out_ready),
        .out_data   (out_data1),
        .level      (level1),
        .xfer_count (xfer_count1),
        .thr_hit    (thr_hit1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"},  {24'd0, out_data},  32'd0);
        chk({tag, "_level"},     {29'd0, level},     32'd0);
        chk({tag, "_xfer"},      {16'd0, xfer_count}, 32'd0);
        chk({tag, "_thr"},       {31'd0, thr_hit},   32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'hxx;
        exp_xfer  = '0;
        exp_thr   = 1'b0;
        exp_thr1  = 1'b0;

        // Reset and idle
        #3;
        chk_reset_outputs("rst");
        step();
        step();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        chk("rst_rel_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("idle_in_ready",  {31'd0, in_ready},  32'd1);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_level",     {29'd0, level},     32'd0);

        // Two pushes held, then drained back to back
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        chk("p1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("p1_out_data",  {24'd0, out_data},  32'hA5);
        in_data = 8'h3C;
        step();
        in_valid = 1'b0;
        in_data  = 8'hxx;
        chk("p2_level",    {29'd0, level},    32'd2);
        chk("p2_out_data", {24'd0, out_data}, 32'hA5);
        step();
        chk("hold_out_data", {24'd0, out_data}, 32'hA5);
        out_ready = 1'b1;
        step();
        chk("drain1_out_data", {24'd0, out_data},   32'h3C);
        chk("drain1_xfer",     {16'd0, xfer_count}, 32'd1);
        step();
        out_ready = 1'b0;
        chk("drain2_xfer",      {16'd0, xfer_count}, 32'd2);
        chk("drain2_level",     {29'd0, level},      32'd0);
        chk("drain2_out_valid", {31'd0, out_valid},  32'd0);
        exp_xfer = 16'd2;

        // Fill to DEPTH; extra word must be refused
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            step();
        end
        chk("full_level",    {29'd0, level},    32'd4);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        in_data = 8'hEE;
        step();
        step();
        chk("full_hold_level", {29'd0, level}, 32'd4);
        out_ready = 1'b1;
        chk("full_pop_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            in_valid = (i == 0);
            exp_word = 8'h10 + 8'(i);
            chk("fill_order", {24'd0, out_data}, {24'd0, exp_word});
            step();
        end
        in_valid = 1'b0;
        chk("fill_empty_level", {29'd0, level},     32'd0);
        chk("fill_out_valid",   {31'd0, out_valid}, 32'd0);
        chk("fill_xfer",        {16'd0, xfer_count}, 32'd6);
        exp_xfer  = 16'd6;
        exp_xfer1 = 4'd6;

        // 300 words streamed with simultaneous push and pop
        pushed    = 0;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic do_push, do_pop;
            do_push = in_valid && in_ready;
            do_pop  = out_valid && out_ready;
            if (do_pop) begin
                exp_word = (q.size() > 0) ? q[0] : 8'hxx;
                chk("stream_data", {24'd0, out_data}, {24'd0, exp_word});
                if (q.size() > 0) void'(q.pop_front());
            end
            if (do_push) begin
                q.push_back(in_data);
                pushed++;
            end
            exp_thr  = exp_thr  | (exp_xfer == 16'd255);
            exp_thr1 = exp_thr1 | (exp_xfer1 == 4'hF);
            if (do_pop) begin
                exp_xfer  = exp_xfer + 16'd1;
                exp_xfer1 = exp_xfer1 + 4'd1;
            end
            step();
            if (cyc % 50 == 0 || exp_xfer == 16'd256 || exp_xfer == 16'd257) begin
                chk("stream_thr",   {31'd0, thr_hit},  {31'd0, exp_thr});
                chk("stream_thr_w4", {31'd0, thr_hit1}, {31'd0, exp_thr1});
                chk("stream_xfer_w4", {28'd0, xfer_count1}, {28'd0, exp_xfer1});
            end
            in_valid = (pushed < 300);
            in_data  = 8'(pushed);
            if (pushed >= 300 && q.size() == 0) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_pushed", pushed,                300);
        chk("stream_level",  {29'd0, level},        32'd0);
        chk("stream_xfer",   {16'd0, xfer_count},   32'd306);
        chk("stream_thr_end", {31'd0, thr_hit},     32'd1);
        chk("w4_xfer_wrap",  {28'd0, xfer_count1},  32'd2);
        chk("w4_thr_sticky", {31'd0, thr_hit1},     32'd1);

        // Mid-stream async reset at level 3
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h50 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        chk("mid_level", {29'd0, level}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        chk("async_rst_w4_xfer", {28'd0, xfer_count1}, 32'd0);
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        in_valid = 1'b0;
        chk("post_rst_push_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_push_data",  {24'd0, out_data},  32'h77);
        chk("post_rst_level",      {29'd0, level},     32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clean3_stream_fifo.md
# clean3_stream_fifo

Parametrised, trojan-free stream buffer: the next-generation clean baseline for the Trojan3 datapath family. Data words enter through a valid/ready port, are held in a DEPTH-entry FIFO, and leave unmodified, in order, through a valid/ready port. A transfer counter and a threshold status flag are provided for observability only; neither ever alters data or flow control. It sits wherever a Trojan-3-style stage is instantiated and serves as the golden reference for equivalence and trigger-detection runs.

## Interface
- DATA_WIDTH, 8: width of data words.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- CNT_WIDTH, 16: width of transfer counter.
- DATA_INCREMENT, 8'd2: kept for parameter compatibility with the Trojan3 family; has no effect on any output.
- TRIGGER_COUNTER_THRESHOLD, 16'd255: value compared against xfer_count to drive thr_hit; zero-extended or truncated to CNT_WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  DATA_WIDTH  upstream word.
- out_valid  out  1  head word valid.
- out_ready  in  1  downstream accepts head word.
- out_data  out  DATA_WIDTH  head word.
- level  out  $clog2(DEPTH+1)  current occupancy.
- xfer_count  out  CNT_WIDTH  completed output handshakes, wrapping.
- thr_hit  out  1  sticky: xfer_count has equalled the threshold since reset.

## Operation
- Reset (rst_n low, async): level=0, write/read pointers=0, out_valid=0, out_data=0, in_ready=0 while asserted, xfer_count=0, thr_hit=0. Storage array need not be cleared.
- Occupancy states, derived from level: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - EMPTY → PARTIAL on push only; PARTIAL → FULL on push without pop at level DEPTH-1; FULL → PARTIAL on pop; PARTIAL → EMPTY on pop without push at level 1; push+pop holds level.
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (level != DEPTH), registered-state function only; never depends on out_ready (no combinational ready path). FULL with out_ready=1 still refuses input that cycle.
- out_valid = (level != 0); out_data = storage[rd_ptr], stable while out_valid & !out_ready.
- Pointers are log2(DEPTH) bits, wrap naturally.
- Data is never modified: out_data equals in_data of the corresponding push, bit for bit.
- xfer_count += 1 per pop, modulo 2^CNT_WIDTH.
- thr_hit sets on the cycle after xfer_count becomes equal to threshold; stays set until reset. Counter wrap does not clear it.

## Timing
- Pushed word visible on out_data/out_valid one cycle after the push edge (latency 1, no bypass).
- Throughput one word/cycle in steady state with simultaneous push and pop.
- level, xfer_count, in_ready, out_valid update on the edge following the handshake.
- Reset mid-stream discards all buffered words immediately; first valid output after release requires a new push.
- Inputs sampled only on rising clk; X on in_data while in_valid=0 must not propagate.

## Structure
- Package clean_stream_pkg: level/pointer width helper functions, FIFO state enum (EMPTY, PARTIAL, FULL), default parameter constants shared with the other clean baselines.
- One sub-module: clean_fifo_mem (DEPTH × DATA_WIDTH register array, one write port, one async read port). Pointers, level, counter and flag live in the top.

## Test plan
- Reset then idle: out_valid=0, level=0, xfer_count=0, thr_hit=0, in_ready=1 one cycle after rst_n rises.
- Push 8'hA5, 8'h3C with out_ready=0: level=2, out_data=8'hA5 held; raise out_ready → A5 then 3C on consecutive cycles, xfer_count=2.
- Fill DEPTH=4 with out_ready=0: in_ready=0 at level 4; a 5th in_valid word is not accepted and never appears at the output.
- Continuous push+pop for 300 words with incrementing data: output sequence identical to input, thr_hit rises after pop #255 and stays 1.
- CNT_WIDTH=4: 17 pops → xfer_count=1 (wrap), thr_hit unchanged by wrap.
- Assert rst_n low with level=3 mid-transfer: all outputs return to reset values asynchronously, buffered words lost; next push emerges after exactly one cycle.
